// File: rtl/fetch_sequencer.sv
// Fetch sequencer: IDLE/ADDR/DATA/EXEC control around a 1-cycle-latency imem.
// Optional macro FETCH_SELF_JUMP_HALT_EN: a self-jump in EXEC enters HALT.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic [31:0] nextpc,
    input  logic [31:0] imem_rdata,
    output logic [7:0]  imem_addr,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        ins_valid,
    output logic [31:0] retired,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        EXEC = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t state;
    state_t state_n;
    logic   retire;

    assign retire = (state == EXEC) && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = ADDR;
            ADDR: state_n = DATA;
            DATA: state_n = EXEC;
            EXEC: begin
                if (!stall) begin
`ifdef FETCH_SELF_JUMP_HALT_EN
                    state_n = (nextpc == pc) ? HALT : ADDR;
`else
                    state_n = ADDR;
`endif
                end
            end
            HALT: state_n = HALT;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode only the state register, never the inputs.
    always_comb begin
        ins_valid = (state == EXEC);
        imem_addr = pc[7:0];
`ifdef FETCH_SELF_JUMP_HALT_EN
        halted = (state == HALT);
`else
        halted = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            ins     <= 32'd0;
            retired <= 32'd0;
        end else begin
            if (state == DATA) ins <= imem_rdata;
            if (retire) begin
                // On a halting self-jump nextpc equals pc, so pc holds.
                pc <= nextpc;
                if (retired != 32'hFFFF_FFFF) retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an issue-order scoreboard.
// Expected (pc, ins) pairs are queued at stimulus time, popped on each new EXEC.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic [31:0] nextpc;
    logic [31:0] imem_rdata;
    logic [7:0]  imem_addr;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        ins_valid;
    logic [31:0] retired;
    logic        halted;

    fetch_sequencer #(.RESET_PC(32'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .nextpc     (nextpc),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .ins        (ins),
        .pc         (pc),
        .ins_valid  (ins_valid),
        .retired    (retired),
        .halted     (halted)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_ret;
    logic [31:0] mem [256];
    logic [63:0] sb_q [$];
    logic        prev_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous imem: address registered, data one cycle later.
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (ins_valid && !prev_v) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_unexpected: observed pc %h with empty queue", pc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", pc, e[63:32]);
                chk("sb_ins", ins, e[31:0]);
            end
        end
        prev_v <= ins_valid;
    end

    // One instruction: wait for EXEC, optionally stall, then check retirement.
    task automatic exec_one(input logic [31:0] p, input int stalls,
                            input logic [31:0] np, input int lat);
        int n;
        logic exp_halt;
        n = 0;
        sb_q.push_back({p, mem[p[7:0]]});
        nextpc = np;
        while (!ins_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        if (!ins_valid) return;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            @(negedge clk);
            chk("stall_valid", 32'(ins_valid), 32'd1);
            chk("stall_pc", pc, p);
            chk("stall_ins", ins, mem[p[7:0]]);
            chk("stall_ret", retired, exp_ret);
        end
        stall = 1'b0;
        @(negedge clk);
        exp_ret = sat_inc(exp_ret);
`ifdef FETCH_SELF_JUMP_HALT_EN
        exp_halt = (np == p);
`else
        exp_halt = 1'b0;
`endif
        chk("retired", retired, exp_ret);
        chk("next_pc", pc, np);
        chk("imem_addr", 32'(imem_addr), 32'(np[7:0]));
        chk("halted", 32'(halted), 32'(exp_halt));
        chk("post_valid", 32'(ins_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h0421_0005;
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        nextpc = 32'd0;
        exp_ret = 32'd0;
        prev_v = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst = 1'b0;

        // No start: sequencer must sit in IDLE.
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", 32'(ins_valid), 32'd0);
            chk("idle_pc", pc, 32'd0);
        end

        start = 1'b1;
        exec_one(32'd0, 0, 32'd1, 3);
        start = 1'b0;
        exec_one(32'd1, 0, 32'd2, 2);
        chk("retired_two", retired, 32'd2);
        exec_one(32'd2, 0, 32'd3, 2);
        exec_one(32'd3, 0, 32'd20, 2);
        start = 1'b1;
        exec_one(32'd20, 0, 32'd5, 2);
        start = 1'b0;
        exec_one(32'd5, 4, 32'd6, 2);
        exec_one(32'd6, 0, 32'd7, 2);

        // Asynchronous reset in the DATA cycle of pc=7.
        @(negedge clk);
        chk("data_valid", 32'(ins_valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ins_valid), 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_retired", retired, 32'd0);
        chk("arst_ins", ins, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 32'd0;

        // Self-jump at pc=9.
        start = 1'b1;
        exec_one(32'd0, 0, 32'd9, 3);
        start = 1'b0;
        exec_one(32'd9, 0, 32'd9, 2);
`ifdef FETCH_SELF_JUMP_HALT_EN
        for (int i = 0; i < 6; i++) begin
            start = ~start;
            @(negedge clk);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_pc", pc, 32'd9);
            chk("halt_valid", 32'(ins_valid), 32'd0);
            chk("halt_retired", retired, exp_ret);
        end
        start = 1'b0;
`else
        exec_one(32'd9, 0, 32'd9, 2);
        exec_one(32'd9, 0, 32'd9, 2);
`endif

        // Saturation of the retired counter.
        do_reset();
        force dut.retired = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.retired;
        @(negedge clk);
        chk("preload", retired, 32'hFFFF_FFFE);
        exp_ret = 32'hFFFF_FFFE;
        start = 1'b1;
        exec_one(32'd0, 0, 32'd1, 3);
        start = 1'b0;
        exec_one(32'd1, 0, 32'd2, 2);
        exec_one(32'd2, 0, 32'd3, 2);
        chk("sat_hold", retired, 32'hFFFF_FFFF);

        @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
